// File: rtl/attention_softmax_if.sv
// Handshake and tensor bus of the softmax stage: start/scores in, probabilities/done out.
interface attention_softmax_if #(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int N          = 1
);
  localparam int TOTAL = DATA_WIDTH * L * N * L;

  logic             start;
  logic [TOTAL-1:0] A_in;
  logic [TOTAL-1:0] P_out;
  logic             done;
  logic             out_valid;

  modport master (output start, A_in, input  P_out, done, out_valid);
  modport slave  (input  start, A_in, output P_out, done, out_valid);
endinterface

// File: rtl/attention_softmax.sv
// Row-wise softmax over an (L,N,L) score tensor using a base-2 shift exp and a
// bit-serial restoring divider (one quotient bit per cycle, MSB first).
module attention_softmax #(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int N          = 1,
  parameter int FRAC       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  attention_softmax_if.slave bus
);
  localparam int ROWS  = L * N;
  localparam int ELEMS = ROWS * L;
  localparam int IW    = (L > 1) ? $clog2(L) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int AW    = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int BW    = $clog2(FRAC + 1);
  localparam int WW    = FRAC + 1;
  localparam int SW    = $clog2(L * (2 ** FRAC) + 1);
  localparam logic [WW-1:0] ONE = WW'(1) << FRAC;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAX, S_SUM, S_DIV, S_DONE} state_t;
  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0] score [ELEMS];
  logic        [WW-1:0]         res   [ELEMS];
  logic        [WW-1:0]         wgt   [L];

  logic signed [DATA_WIDTH-1:0] m, x;
  logic [SW-1:0]       sum, rem, rem_cur;
  logic [WW-1:0]       quo, q_nxt, w_cur;
  logic [IW-1:0]       idx;
  logic [BW-1:0]       bcnt;
  logic [RW-1:0]       row;
  logic [AW-1:0]       elem;
  logic [DATA_WIDTH:0] diff;
  logic [SW:0]         trial, trial_sub;
  logic                dbit, qbit, last_idx, last_bit, last_row;
  logic [DATA_WIDTH*ELEMS-1:0] p_pack;

  assign last_idx = (idx == IW'(L - 1));
  assign last_bit = (bcnt == BW'(FRAC));
  assign last_row = (row == RW'(ROWS - 1));
  assign elem     = AW'(row) * AW'(L) + AW'(idx);
  assign x        = score[elem];

  // Sign-extending both operands to DATA_WIDTH+1 bits keeps m - x exact even for 32767 - (-32768).
  assign diff  = {m[DATA_WIDTH-1], m} - {x[DATA_WIDTH-1], x};
  assign w_cur = (diff <= (DATA_WIDTH + 1)'(FRAC)) ? (ONE >> diff) : '0;

  // Dividend is w << FRAC; its upper bits (w >> 1) are already below S, so the
  // FRAC+1 quotient steps only ever shift in w[0] followed by zeros.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    rem_cur   = (bcnt == '0) ? SW'(wgt[idx] >> 1) : rem;
    dbit      = (bcnt == '0) ? wgt[idx][0] : 1'b0;
    trial     = {rem_cur, dbit};
    trial_sub = trial - {1'b0, sum};
    qbit      = (trial >= {1'b0, sum});
    q_nxt     = {((bcnt == '0) ? {(WW - 1){1'b0}} : quo[WW-2:0]), qbit};
  end

  // Final image of all results, with the element finishing this cycle merged in.
  always_comb begin
    p_pack = '0;
    for (int e = 0; e < ELEMS; e++)
      p_pack[e*DATA_WIDTH +: WW] = (AW'(e) == elem) ? q_nxt : res[e];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    // NOTE: sequential state always uses non-blocking assignment.
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_MAX;
      S_MAX:   if (last_idx) state_nxt = S_SUM;
      S_SUM:   if (last_idx) state_nxt = S_DIV;
      S_DIV:   if (last_idx && last_bit) state_nxt = last_row ? S_DONE : S_MAX;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      bcnt      <= '0;
      row       <= '0;
      m         <= '0;
      sum       <= '0;
      rem       <= '0;
      quo       <= '0;
      bus.P_out <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          row  <= '0;
          idx  <= '0;
          bcnt <= '0;
        end
        S_MAX: begin
          if (idx == '0 || x > m) m <= x;
          idx <= last_idx ? '0 : idx + 1'b1;
        end
        S_SUM: begin
          sum <= (idx == '0) ? SW'(w_cur) : sum + SW'(w_cur);
          idx <= last_idx ? '0 : idx + 1'b1;
        end
        S_DIV: begin
          rem <= qbit ? trial_sub[SW-1:0] : trial[SW-1:0];
          quo <= q_nxt;
          if (last_bit) begin
            bcnt <= '0;
            idx  <= last_idx ? '0 : idx + 1'b1;
            if (last_idx && !last_row) row <= row + 1'b1;
            if (last_idx && last_row)  bus.P_out <= p_pack;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: storage arrays carry no reset; they are always written before being read in a run.
  always_ff @(posedge clk) begin
    if (state == S_LOAD)
      for (int e = 0; e < ELEMS; e++) score[e] <= bus.A_in[e*DATA_WIDTH +: DATA_WIDTH];
    if (state == S_SUM) wgt[idx] <= w_cur;
    if (state == S_DIV && last_bit) res[elem] <= q_nxt;
  end

  assign bus.done      = (state == S_DONE);
  assign bus.out_valid = (state == S_DONE);
endmodule

// File: tb/tb_attention_softmax.sv
// Self-checking bench for attention_softmax: randomized and directed score tensors
// compared every cycle against an arithmetic softmax model.
module tb_attention_softmax;
  localparam int DW    = 16;
  localparam int L     = 8;
  localparam int N     = 1;
  localparam int FRAC  = 8;
  localparam int ROWS  = L * N;
  localparam int ELEMS = ROWS * L;
  localparam int TOTAL = DW * ELEMS;
  localparam int LAT   = 1 + ROWS * (2 * L + L * (FRAC + 1));

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   sc [ELEMS];

  attention_softmax_if #(.DATA_WIDTH(DW), .L(L), .N(N)) bus ();

  attention_softmax #(.DATA_WIDTH(DW), .L(L), .N(N), .FRAC(FRAC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [TOTAL-1:0] act, input logic [TOTAL-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [TOTAL-1:0] softmax_model(input logic [TOTAL-1:0] a);
    logic [TOTAL-1:0] p;
    int xv [L];
    int wv [L];
    int mx, s;
    p = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int l2 = 0; l2 < L; l2++) begin
        logic signed [DW-1:0] t;
        t = a[(r*L+l2)*DW +: DW];
        xv[l2] = int'(t);
      end
      mx = xv[0];
      for (int l2 = 1; l2 < L; l2++) if (xv[l2] > mx) mx = xv[l2];
      s = 0;
      for (int l2 = 0; l2 < L; l2++) begin
        wv[l2] = (mx - xv[l2] <= FRAC) ? ((1 << FRAC) >> (mx - xv[l2])) : 0;
        s += wv[l2];
      end
      for (int l2 = 0; l2 < L; l2++) p[(r*L+l2)*DW +: DW] = DW'((wv[l2] << FRAC) / s);
    end
    return p;
  endfunction

  function automatic logic [TOTAL-1:0] pack_scores();
    logic [TOTAL-1:0] v;
    v = '0;
    for (int e = 0; e < ELEMS; e++) v[e*DW +: DW] = DW'(sc[e]);
    return v;
  endfunction

  function automatic int rnd_score();
    logic signed [DW-1:0] v;
    v = DW'($urandom);
    return int'(v);
  endfunction

  task automatic set_row(input int r, input int v);
    for (int l2 = 0; l2 < L; l2++) sc[r*L+l2] = v;
  endtask

  // Half the rows span the full range (mostly one-hot), half a narrow window (real divisions).
  task automatic rand_row(input int r);
    int base;
    if ($urandom_range(0, 1) == 1) begin
      for (int l2 = 0; l2 < L; l2++) sc[r*L+l2] = rnd_score();
    end else begin
      base = int'($urandom_range(0, 64000)) - 32000;
      for (int l2 = 0; l2 < L; l2++) sc[r*L+l2] = base + int'($urandom_range(0, 10));
    end
  endtask

  task automatic rand_all();
    for (int r = 0; r < ROWS; r++) rand_row(r);
  endtask

  function automatic int p_at(input int r, input int l2);
    return int'(bus.P_out[(r*L+l2)*DW +: DW]);
  endfunction

  // Reference model: tracks run acceptance and the captured tensor from the
  // externally visible rules only (start seen while idle, capture one edge later).
  logic             mdl_busy = 1'b0;
  int               mdl_cnt  = 0;
  logic [TOTAL-1:0] mdl_a    = '0;
  logic [TOTAL-1:0] exp_p    = '0;
  logic             exp_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_busy = 1'b0;
      mdl_cnt  = 0;
      exp_p    = '0;
      exp_done = 1'b0;
    end else if (mdl_busy) begin
      mdl_cnt++;
      if (mdl_cnt == 1) mdl_a = bus.A_in;
      exp_done = (mdl_cnt == LAT);
      if (mdl_cnt == LAT) exp_p = softmax_model(mdl_a);
      if (mdl_cnt == LAT + 1) mdl_busy = 1'b0;
    end else if (bus.start) begin
      mdl_busy = 1'b1;
      mdl_cnt  = 0;
    end
  end

  always @(negedge clk) begin
    check("done", TOTAL'(bus.done), TOTAL'(exp_done));
    check("out_valid", TOTAL'(bus.out_valid), TOTAL'(exp_done));
    check("P_out", bus.P_out, exp_p);
  end

  task automatic do_run(input string name);
    int lat;
    @(posedge clk); #1;
    bus.A_in  = pack_scores();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= LAT + 50; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    check(name, TOTAL'(lat), TOTAL'(LAT));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, ndone, lat;
    bus.start = 1'b0;
    bus.A_in  = '0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    #1;
    check("reset_p_out", bus.P_out, '0);
    check("reset_done", TOTAL'(bus.done), '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // All scores zero: uniform 1/8.
    for (int e = 0; e < ELEMS; e++) sc[e] = 0;
    do_run("latency_zero");
    check("zero_first", TOTAL'(p_at(0, 0)), TOTAL'(32));
    check("zero_last", TOTAL'(p_at(7, 7)), TOTAL'(32));

    // One slightly larger element, other rows flat at random levels.
    set_row(0, 0);
    sc[0] = 1;
    for (int r = 1; r < ROWS; r++) set_row(r, rnd_score());
    do_run("latency_one_up");
    check("one_up_e0", TOTAL'(p_at(0, 0)), TOTAL'(56));
    check("one_up_e1", TOTAL'(p_at(0, 1)), TOTAL'(28));
    check("one_up_e7", TOTAL'(p_at(0, 7)), TOTAL'(28));
    check("flat_row5", TOTAL'(p_at(5, 3)), TOTAL'(32));

    // Far-below cutoff, ties, and full-range extremes.
    set_row(0, 0);       sc[0] = 10;
    set_row(1, -100);    sc[8] = 5; sc[9] = 5;
    set_row(2, -32768);  sc[16] = 32767;
    set_row(3, -32768);  sc[31] = 32767;
    set_row(4, 0);
    for (int r = 5; r < ROWS; r++) rand_row(r);
    do_run("latency_edges");
    check("cut_e0", TOTAL'(p_at(0, 0)), TOTAL'(256));
    check("cut_e1", TOTAL'(p_at(0, 1)), TOTAL'(0));
    check("tie_e0", TOTAL'(p_at(1, 0)), TOTAL'(128));
    check("tie_e1", TOTAL'(p_at(1, 1)), TOTAL'(128));
    check("tie_e2", TOTAL'(p_at(1, 2)), TOTAL'(0));
    check("ext_first_max", TOTAL'(p_at(2, 0)), TOTAL'(256));
    check("ext_first_other", TOTAL'(p_at(2, 5)), TOTAL'(0));
    check("ext_last_max", TOTAL'(p_at(3, 7)), TOTAL'(256));
    check("ext_last_other", TOTAL'(p_at(3, 0)), TOTAL'(0));
    check("zero_row4", TOTAL'(p_at(4, 4)), TOTAL'(32));

    for (int k = 0; k < 4; k++) begin
      rand_all();
      do_run("latency_random");
    end

    // Second start mid-run plus A_in change after capture: ignored.
    rand_all();
    set_row(0, 0);
    sc[0] = 1;
    @(posedge clk); #1;
    bus.A_in  = pack_scores();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    bus.start = 1'b1;
    rand_all();
    bus.A_in = pack_scores();
    @(posedge clk); #1;
    bus.start = 1'b0;
    ndone = 0;
    lat   = -1;
    for (int k = 102; k <= LAT + 20; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        ndone++;
        if (lat < 0) lat = k;
      end
    end
    check("midrun_latency", TOTAL'(lat), TOTAL'(LAT));
    check("midrun_done_count", TOTAL'(ndone), TOTAL'(1));
    check("midrun_captured", TOTAL'(p_at(0, 0)), TOTAL'(56));

    // start held high: back-to-back runs one idle cycle apart.
    rand_all();
    @(posedge clk); #1;
    bus.A_in  = pack_scores();
    bus.start = 1'b1;
    c1 = -1;
    c2 = -1;
    for (int k = 1; k <= 2 * LAT + 40 && c2 < 0; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        if (c1 < 0) begin
          c1 = k;
          rand_all();
          bus.A_in = pack_scores();
        end else begin
          c2 = k;
        end
      end
    end
    bus.start = 1'b0;
    check("b2b_first", TOTAL'(c1), TOTAL'(LAT + 1));
    check("b2b_gap", TOTAL'(c2 - c1), TOTAL'(LAT + 2));

    // Reset while row 3 is dividing: outputs clear at once, then a clean run.
    rand_all();
    @(posedge clk); #1;
    bus.A_in  = pack_scores();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (300) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_p_out", bus.P_out, '0);
    check("abort_done", TOTAL'(bus.done), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rand_all();
    do_run("latency_after_abort");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/attention_softmax.md
# attention_softmax

Row-wise fixed-point softmax stage that sits directly downstream of the attention score block. It captures one (L, N, L) tensor of signed raw scores and normalises each (l, n) row of L scores into probabilities. Each row uses a base-2 shift approximation of exp with a sequential restoring divider. Its output feeds the attention-weighted value (A·V) stage.

## Interface

Parameters:
- DATA_WIDTH, 16: width of each score and each probability element.
- L, 8: sequence length; row length and number of rows per head.
- N, 1: batch/head count.
- FRAC, 8: fractional bits of the output probability (Q0.FRAC, 1.0 = 2^FRAC); legal range 1..DATA_WIDTH-2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a run; sampled only in IDLE.
- A_in  in  DATA_WIDTH*L*N*L  signed raw scores; element (l,n,l2) at bit offset ((l*N+n)*L+l2)*DATA_WIDTH.
- P_out  out  DATA_WIDTH*L*N*L  unsigned probabilities, same packing as A_in; value in low FRAC+1 bits, upper bits zero.
- done  out  1  one-cycle completion pulse.
- out_valid  out  1  one-cycle pulse, identical to done.

## Operation

- States: IDLE, LOAD, MAX, SUM, DIV, DONE.
- IDLE: wait for start. start=1 → LOAD. start in any other state is ignored and does not restart.
- LOAD (1 cycle): register all of A_in into an internal array. A_in may change afterwards. Row counter r=0 (r = l*N+n).
- MAX (L cycles): scan row r; m = signed maximum. → SUM.
- SUM (L cycles): for each element, d = m - x as an unsigned DATA_WIDTH+1 value (no overflow for any signed inputs). w = 2^FRAC >> d if d ≤ FRAC, else 0. Store w per element. Accumulate S = Σw, sized to hold L*2^FRAC. The max element always gives w=2^FRAC, so S ≥ 2^FRAC and division by zero cannot occur. → DIV.
- DIV (L*(FRAC+1) cycles): for each element in order l2=0..L-1, run an unsigned restoring division p = floor(w*2^FRAC / S). Each division produces one quotient bit per cycle, MSB first, FRAC+1 bits, then writes p into the internal result array. After the last element: if r < L*N-1, set r++ and go to MAX; else go to DONE.
- DONE (1 cycle): P_out holds all results; done=out_valid=1. → IDLE.
- P_out is updated only on the edge entering DONE. It holds its value until the next run's DONE or reset.
- Ties: every maximal element receives w=2^FRAC.

## Timing

- Reset (async assert): state=IDLE; P_out=0; done=0; out_valid=0; all counters cleared. Reset mid-run aborts the run with no partial P_out update.
- Latency: start sampled at edge E0 → DONE state (done=1, new P_out visible) during the cycle after edge E0 + 1 + L*N*(2L + L*(FRAC+1)). Defaults: E0+705.
- done/out_valid are high for exactly one cycle per run, then low.
- Earliest next start is accepted on the first cycle back in IDLE, i.e. the cycle after done. Back-to-back runs therefore have 1 idle cycle.
- start held high continuously causes repeated runs, each separated by one IDLE cycle.
- Row r's results depend only on row r's captured scores. Rows are processed in increasing r.

## Test plan

- All scores 0, defaults → every element: w=256, S=2048, so every P_out element = 32; done pulses once at E0+705.
- Row [1,0,0,0,0,0,0,0] → P_out [56,28,28,28,28,28,28,28] (S=1152). Other rows with all-equal scores → 32 each.
- Row [10,0,…,0] (d=10>FRAC) → [256,0,…,0]. Row [5,5,-100,…] → [128,128,0,…,0].
- Row mixing 32767 and -32768 (d=65535) → no wrap: 256 at the max positions (one max) and 0 elsewhere. Repeat with the max at l2=L-1.
- Pulse start again mid-run and change A_in after LOAD → no restart; result reflects the inputs captured in LOAD; exactly one done pulse.
- Assert rst_n=0 during DIV of row 3 → P_out=0 and done=0 immediately. After release, a fresh run completes in 705 cycles with correct values.
